// File: rtl/cdclib_hstx.sv
// Write-side toggle handshake transmitter: captures a payload, toggles req_lvl, waits for ack_lvl to match.
// Optional acknowledge timeout with ERR recovery is enabled by defining CDCLIB_HSTX_TIMEOUT_EN.
module cdclib_hstx #(
  parameter int DWIDTH         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  input  logic              req_in,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              ack_lvl,
  input  logic              err_clr,
  output logic              req_lvl,
  output logic [DWIDTH-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              drop_err,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, ERR} state_t;

  state_t state, next_state;
  logic   match;
  logic   accept;
  logic   complete;
  logic   drop;
  logic   timeout_hit;

  assign match = (ack_lvl == req_lvl);

`ifdef CDCLIB_HSTX_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt;

  assign timeout_hit = (state == WAIT_ACK) && !match && (cnt == TO_LAST);

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept)
        cnt <= '0;
      else if (state == WAIT_ACK)
        cnt <= cnt + 16'd1;
      if (timeout_hit)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (req_in) next_state = WAIT_ACK;
      WAIT_ACK: begin
        if (match)
          next_state = IDLE;
        else if (timeout_hit)
          next_state = ERR;
      end
      ERR:      if (match) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // A late ack out of ERR returns to IDLE without counting as a completion.
  always_comb begin
    busy     = (state != IDLE);
    accept   = (state == IDLE) && req_in;
    complete = (state == WAIT_ACK) && match;
    drop     = busy && req_in;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      req_lvl  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (accept) begin
        req_lvl  <= ~req_lvl;
        data_out <= data_in;
      end
      done <= complete;
      if (drop)
        drop_err <= 1'b1;
      else if (err_clr)
        drop_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdclib_hstx.sv
// Directed bench for cdclib_hstx; the timeout section is active when CDCLIB_HSTX_TIMEOUT_EN is defined.
module tb_cdclib_hstx;

  logic       wr_clk = 1'b0;
  logic       wr_rst_n;
  logic       req_in;
  logic [7:0] data_in;
  logic       ack_lvl;
  logic       err_clr;
  logic       req_lvl;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       drop_err;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  cdclib_hstx #(.DWIDTH(8), .TIMEOUT_CYCLES(4)) dut (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .req_in      (req_in),
    .data_in     (data_in),
    .ack_lvl     (ack_lvl),
    .err_clr     (err_clr),
    .req_lvl     (req_lvl),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .drop_err    (drop_err),
    .timeout_err (timeout_err)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic tick;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [7:0] data,
                               input logic ack, input logic clr);
    req_in  = req;
    data_in = data;
    ack_lvl = ack;
    err_clr = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed view: {req_lvl, busy, done, drop_err, timeout_err, data_out}
  function automatic logic [12:0] snap();
    return {req_lvl, busy, done, drop_err, timeout_err, data_out};
  endfunction

  initial begin
    wr_rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    checkOutput("reset_state", 32'(snap()), 32'h0);
    tick();
    wr_rst_n = 1'b1;
    tick();
    checkOutput("idle_after_reset", 32'(snap()), 32'h0);

    // Basic accept of 0xA5
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("accept_a5", 32'(snap()), {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5});

    // Request while waiting is dropped and flagged
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("drop_in_wait", 32'(snap()), {19'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5});

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("clear_drop", 32'(snap()), {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5});

    // Ack arrives, completion
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("complete_a5", 32'(snap()), {19'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5});

    // Back-to-back request in the done cycle
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("b2b_accept_3c", 32'(snap()), {19'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C});

    // Drop event and err_clr in the same cycle: set wins
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("set_beats_clear", 32'(drop_err), 32'h1);
    checkOutput("data_held_3c", 32'(data_out), 32'h3C);

    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("clear_again", 32'(drop_err), 32'h0);

    // Request on the completing cycle is dropped
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("drop_on_complete", 32'(snap()), {19'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C});
    tick();
    checkOutput("done_one_cycle", 32'(done), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("clear_idle", 32'(drop_err), 32'h0);

    // Protocol fault in IDLE: no reaction
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("idle_fault", 32'(snap()), {19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C});
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Reset mid-transfer
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("accept_5a", 32'(snap()), {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A});
    #2;
    wr_rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 32'(snap()), 32'h0);
    tick();
    wr_rst_n = 1'b1;
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("accept_after_reset", 32'(snap()), {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3});
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("complete_c3", 32'(snap()), {19'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3});
    tick();

    // Ack withheld: req_lvl goes 1 -> 0 while ack_lvl stays 1
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("accept_99", 32'(snap()), {19'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99});
    tick();
    tick();
    tick();
    checkOutput("no_timeout_yet", 32'(timeout_err), 32'h0);
    tick();
`ifdef CDCLIB_HSTX_TIMEOUT_EN
    checkOutput("timeout_set", 32'(snap()), {19'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99});
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("late_ack_no_done", 32'(snap()), {19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99});
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("timeout_cleared", 32'(timeout_err), 32'h0);
`else
    tick();
    checkOutput("wait_forever", 32'(snap()), {19'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99});
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("late_complete", 32'(snap()), {19'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
